// File: rtl/nes_video_pkg.sv
// Shared NES video definitions: timing constants, the pixel FIFO entry and the RGB palette.
package nes_video_pkg;

  localparam int NES_VIS_W        = 256;
  localparam int NES_VIS_H        = 240;
  localparam int NES_CYC_PER_LINE = 341;
  localparam int NES_LINES        = 262;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [5:0] color;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    WAIT_SOF,
    STREAM,
    RESYNC
  } wr_state_t;

  // 2C02 palette as {R,G,B}, indexed by the 6-bit PPU color.
  localparam logic [23:0] NES_PALETTE [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

endpackage

// File: rtl/nes_palette_rom.sv
// Registered 6-bit palette index to 24-bit RGB lookup; holds its output while en is low.
module nes_palette_rom
  import nes_video_pkg::*;
(
  input  logic        clk,
  input  logic        en,
  input  logic [5:0]  idx,
  output logic [23:0] rgb
);

  always_ff @(posedge clk) begin
    if (en) rgb <= NES_PALETTE[idx];
  end

endmodule

// File: rtl/nes_axis_video_tx.sv
// PPU pixel stream to AXI4-Stream video: visible-pixel filter, resync FSM, pixel FIFO, palette and output stage.
// Optional NES_AXIS_STATS_EN adds frame_count and drop_count outputs.
module nes_axis_video_tx
  import nes_video_pkg::*;
#(
  parameter int FIFO_DEPTH = 512,
  parameter int TDATA_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ppu_ce,
  input  logic [5:0]         color,
  input  logic [8:0]         scanline,
  input  logic [8:0]         cycle,
  output logic [TDATA_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast,
  input  logic               ovf_clr,
  output logic               overflow
`ifdef NES_AXIS_STATS_EN
  ,
  output logic [15:0]        frame_count,
  output logic [15:0]        drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  wr_state_t   state, state_nxt;
  fifo_entry_t mem [FIFO_DEPTH];
  fifo_entry_t head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        visible, is_sof, is_eol;
  logic        fifo_empty, fifo_full, fifo_rd, can_write, wr_en, drop;
  logic        out_ready, s1_ready, s1_valid, s1_sof, s1_eol;
  logic [23:0] s1_rgb;

  assign visible = ppu_ce && (scanline < 9'(NES_VIS_H)) && (cycle >= 9'd1) && (cycle <= 9'(NES_VIS_W));
  assign is_sof  = visible && (scanline == 9'd0) && (cycle == 9'd1);
  assign is_eol  = visible && (cycle == 9'(NES_VIS_W));

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];
  // A full FIFO still takes a write when the head is leaving in the same cycle.
  assign can_write  = !fifo_full || fifo_rd;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_nxt;
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF, RESYNC: if (is_sof) state_nxt = can_write ? STREAM : RESYNC;
      STREAM:           if (visible && !can_write) state_nxt = RESYNC;
      default:          state_nxt = WAIT_SOF;
    endcase
  end

  always_comb begin
    wr_en = 1'b0;
    drop  = 1'b0;
    case (state)
      WAIT_SOF, RESYNC: begin
        wr_en = is_sof && can_write;
        drop  = is_sof && !can_write;
      end
      STREAM: begin
        wr_en = visible && can_write;
        drop  = visible && !can_write;
      end
      default: ;
    endcase
  end

  // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= '{sof: is_sof, eol: is_eol, color: color};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Two-stage skid-free pipeline: each stage loads whenever it is empty or its consumer is taking it.
  assign out_ready = !m_axis_tvalid || m_axis_tready;
  assign s1_ready  = !s1_valid || out_ready;
  assign fifo_rd   = !fifo_empty && s1_ready;

  nes_palette_rom u_palette (
    .clk (clk),
    .en  (s1_ready),
    .idx (head.color),
    .rgb (s1_rgb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= fifo_rd;
      s1_sof   <= head.sof;
      s1_eol   <= head.eol;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (out_ready) begin
      m_axis_tvalid <= s1_valid;
      if (s1_valid) begin
        m_axis_tdata <= TDATA_W'(s1_rgb);
        m_axis_tuser <= s1_sof;
        m_axis_tlast <= s1_eol;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef NES_AXIS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tuser) frame_count <= frame_count + 1'b1;
      if (ovf_clr)                           drop_count <= {15'd0, drop};
      else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nes_axis_video_tx.sv
// Self-checking bench for nes_axis_video_tx: boundary vector table plus shortened-frame stream tests.
module tb_nes_axis_video_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ppu_ce = 1'b0;
  logic [5:0]  color = '0;
  logic [8:0]  scanline = '0;
  logic [8:0]  cycle = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        ovf_clr = 1'b0;
  logic        overflow;
`ifdef NES_AXIS_STATS_EN
  logic [15:0] frame_count, drop_count;
`endif

  nes_axis_video_tx #(.FIFO_DEPTH(512), .TDATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ppu_ce        (ppu_ce),
    .color         (color),
    .scanline      (scanline),
    .cycle         (cycle),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .ovf_clr       (ovf_clr),
`ifdef NES_AXIS_STATS_EN
    .frame_count   (frame_count),
    .drop_count    (drop_count),
`endif
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] PAL [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    int         sl;
    int         cy;
    logic       exp_beat;
    logic       exp_user;
    logic       exp_last;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  beat_t rx_q[$];
  beat_t exp_q[$];
  beat_t exp_a[$];
  bit    model_sync = 0;
  bit    rand_ready = 0;
  int    stall_left = 0;
  bit    prev_stall = 0;
  beat_t prev_beat;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a visible pixel becomes a beat once the stream has seen a frame start.
  task automatic model(input int sl, input int cy, input logic [5:0] col);
    bit vis, sof, eol;
    vis = (sl < 240) && (cy >= 1) && (cy <= 256);
    sof = vis && sl == 0 && cy == 1;
    eol = vis && cy == 256;
    if (sof) model_sync = 1;
    if (vis && model_sync) exp_q.push_back('{user: sof, last: eol, data: {8'h00, PAL[col]}});
  endtask

  task automatic slot(input int sl, input int cy, input logic [5:0] col, input int gap);
    ppu_ce = 1'b1; scanline = 9'(sl); cycle = 9'(cy); color = col;
    model(sl, cy, col);
    @(posedge clk); #1;
    ppu_ce = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic line(input int sl, input int gap, input bit rnd);
    logic [5:0] c;
    slot(sl, 0, 6'($urandom), gap);
    for (int cy = 1; cy <= 256; cy++) begin
      c = rnd ? 6'($urandom) : 6'(cy - 1);
      slot(sl, cy, c, gap);
    end
    slot(sl, 257, 6'($urandom), gap);
    slot(sl, 340, 6'($urandom), gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rx_q.delete(); exp_q.delete();
    model_sync = 0;
  endtask

  task automatic drain();
    int idle = 0;
    for (int i = 0; i < 20000 && idle < 16; i++) begin
      @(posedge clk); #1;
      if (m_axis_tvalid || stall_left > 0) idle = 0;
      else idle++;
    end
    check("drain_timeout", idle >= 16, 1);
  endtask

  task automatic cmp_stream(input string name);
    int bad = 0;
    int n;
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    check({name, "_beats"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) bad++;
    check({name, "_mismatches"}, bad, 0);
  endtask

  // Downstream ready driver: random, stalled for a counted window, or always ready.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      else if (stall_left > 0) begin m_axis_tready = 1'b0; stall_left--; end
      else m_axis_tready = 1'b1;
    end
  end

  // Beat monitor and stall-stability checks, sampled mid-cycle.
  always @(negedge clk) begin
    beat_t cur;
    cur = '{user: m_axis_tuser, last: m_axis_tlast, data: m_axis_tdata};
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_beat", cur, prev_beat);
      end
      if (m_axis_tvalid && m_axis_tready) rx_q.push_back(cur);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    int   k;
    logic [5:0] c;

    vecs = '{
      '{5,   1,   0, 0, 0}, '{0,   0,   0, 0, 0}, '{0,   1,   1, 1, 0}, '{0,   2,   1, 0, 0},
      '{0,   256, 1, 0, 1}, '{0,   257, 0, 0, 0}, '{0,   340, 0, 0, 0}, '{239, 1,   1, 0, 0},
      '{239, 256, 1, 0, 1}, '{240, 1,   0, 0, 0}, '{261, 128, 0, 0, 0}, '{120, 0,   0, 0, 0},
      '{120, 128, 1, 0, 0}
    };

    repeat (2) @(posedge clk); #1;
    do_reset();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_overflow", overflow, 0);

    // Boundary vectors: visibility window, sof/eol flags and two-edge latency.
    foreach (vecs[i]) begin
      c = 6'($urandom);
      ppu_ce = 1'b1; scanline = 9'(vecs[i].sl); cycle = 9'(vecs[i].cy); color = c;
      @(posedge clk); #1;
      ppu_ce = 1'b0;
      @(posedge clk); #1;
      check($sformatf("vec%0d_early_tvalid", i), m_axis_tvalid, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vecs[i].exp_beat);
      if (vecs[i].exp_beat) begin
        check($sformatf("vec%0d_tdata", i), m_axis_tdata, {8'h00, PAL[c]});
        check($sformatf("vec%0d_tuser", i), m_axis_tuser, vecs[i].exp_user);
        check($sformatf("vec%0d_tlast", i), m_axis_tlast, vecs[i].exp_last);
      end
    end
`ifdef NES_AXIS_STATS_EN
    check("vec_frame_count", frame_count, 1);
    check("vec_drop_count", drop_count, 0);
`endif

    // Full-rate frame, color = x.
    do_reset();
    for (int sl = 0; sl < 8; sl++) line(sl, 0, 0);
    drain();
    cmp_stream("frame");
    check("frame_overflow", overflow, 0);
`ifdef NES_AXIS_STATS_EN
    check("frame_count_one", frame_count, 1);
`endif

    // Reset in the middle of a frame.
    do_reset();
    for (int sl = 0; sl < 3; sl++) line(sl, 0, 0);
    for (int cy = 1; cy < 50; cy++) slot(100, cy, 6'(cy - 1), 0);
    rst = 1'b1;
    slot(100, 50, 6'd49, 0);
    rst = 1'b0;
    rx_q.delete(); exp_q.delete(); model_sync = 0;
    check("midrst_tvalid", m_axis_tvalid, 0);
    for (int cy = 51; cy <= 256; cy++) slot(100, cy, 6'(cy - 1), 0);
    line(101, 0, 0);
    check("midrst_no_beats", rx_q.size(), 0);
    for (int sl = 0; sl < 3; sl++) line(sl, 0, 0);
    drain();
    cmp_stream("midrst");
    check("midrst_first_tuser", rx_q.size() > 0 && rx_q[0].user, 1);

    // Long stall at PPU rate: no loss.
    do_reset();
    for (int sl = 0; sl < 8; sl++) begin
      if (sl == 3) stall_left = 1500;
      line(sl, 3, 1);
    end
    drain();
    cmp_stream("stall");
    check("stall_overflow", overflow, 0);

    // Four-line stall at full rate: overflow, truncation, clean next frame.
    do_reset();
    for (int sl = 0; sl < 8; sl++) begin
      if (sl == 2) stall_left = 4 * 260;
      line(sl, 0, 1);
    end
    exp_a = exp_q;
    exp_q.delete();
    for (int sl = 0; sl < 3; sl++) line(0 + sl, 0, 1);
    drain();
    check("ovf_flag", overflow, 1);
`ifdef NES_AXIS_STATS_EN
    check("ovf_drop_count_nonzero", drop_count != 0, 1);
`endif
    k = -1;
    for (int i = 1; i < rx_q.size() && k < 0; i++) if (rx_q[i].user) k = i;
    check("ovf_truncated", k > 0 && k < exp_a.size(), 1);
    if (k > 0) begin
      int bad = 0;
      for (int i = 0; i < k && i < exp_a.size(); i++) if (rx_q[i] !== exp_a[i]) bad++;
      check("ovf_prefix_mismatches", bad, 0);
      for (int i = 0; i < k; i++) void'(rx_q.pop_front());
      cmp_stream("ovf_next_frame");
    end
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
`ifdef NES_AXIS_STATS_EN
    check("ovf_clr_drop_count", drop_count, 0);
`endif

    // Random backpressure over two frames.
    do_reset();
    rand_ready = 1;
    for (int f = 0; f < 2; f++)
      for (int sl = 0; sl < 6; sl++) line(sl, 2, 1);
    rand_ready = 0;
    drain();
    cmp_stream("random");
    check("random_overflow", overflow, 0);

    // Non-visible slots after sync produce nothing beyond the sync pixel.
    do_reset();
    slot(0, 1, 6'($urandom), 0);
    for (int sl = 240; sl < 262; sl++) begin
      slot(sl, 0, 6'($urandom), 0);
      slot(sl, 1, 6'($urandom), 0);
      slot(sl, 128, 6'($urandom), 0);
      slot(sl, 256, 6'($urandom), 0);
      slot(sl, 300, 6'($urandom), 0);
    end
    slot(10, 0, 6'($urandom), 0);
    for (int cy = 257; cy <= 340; cy++) slot(10, cy, 6'($urandom), 0);
    drain();
    cmp_stream("nonvisible");
    check("nonvisible_overflow", overflow, 0);
`ifdef NES_AXIS_STATS_EN
    check("nonvisible_frame_count", frame_count, 1);
    check("nonvisible_drop_count", drop_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
